// File: rtl/rc5_pkg.sv
// rc5_pkg: shared types and constants for the RC5 datapath and its key schedule.
//   state_t : control FSM states of rc5_core (IDLE, RUN, DONE)
//   mode_t  : transaction direction (ENC, DEC)
//   P/Q     : RC5 magic constants for W = 16/32/64, used by the key-schedule block
//   block_w : block width in bits for a given word width
package rc5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_t;

  localparam logic [15:0] P16 = 16'hB7E1;
  localparam logic [15:0] Q16 = 16'h9E37;
  localparam logic [31:0] P32 = 32'hB7E1_5163;
  localparam logic [31:0] Q32 = 32'h9E37_79B9;
  localparam logic [63:0] P64 = 64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] Q64 = 64'h9E37_79B9_7F4A_7C15;

  function automatic int block_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/rc5_rot.sv
// rc5_rot: combinational W-bit rotator, built as a log2(W)-stage barrel shifter.
//   data   : word to rotate
//   amt    : rotate amount (low LGW bits of the controlling word)
//   dir    : 0 = rotate left, 1 = rotate right
//   result : rotated word
module rc5_rot #(
  parameter  int W   = 16,
  localparam int LGW = $clog2(W)
) (
  input  logic [W-1:0]   data,
  input  logic [LGW-1:0] amt,
  input  logic           dir,
  output logic [W-1:0]   result
);

  logic [W-1:0] stage [LGW+1];

  assign stage[0] = data;

  // Stage gi rotates by 2**gi when amt[gi] is set.
  for (genvar gi = 0; gi < LGW; gi++) begin : g_stage
    localparam int K = 1 << gi;
    logic [W-1:0] rot_l;
    logic [W-1:0] rot_r;
    assign rot_l = {stage[gi][W-1-K:0], stage[gi][W-1:W-K]};
    assign rot_r = {stage[gi][K-1:0], stage[gi][W-1:K]};
    assign stage[gi+1] = amt[gi] ? (dir ? rot_r : rot_l) : stage[gi];
  end

  assign result = stage[LGW];

endmodule

// File: rtl/rc5_core.sv
// rc5_core: RC5-W/R/b encrypt/decrypt datapath, one round per clock.
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_mode, in_rounds, in_data sampled on accept
//   in_data             : block, [W-1:0] = A, [2W-1:W] = B
//   out_valid/out_ready : output handshake; out_data = {B, A}
//   sk_we/sk_addr/sk_data : subkey table write port, honoured only while idle
module rc5_core
  import rc5_pkg::*;
#(
  parameter  int W          = 16,
  parameter  int MAX_ROUNDS = 16,
  localparam int LGW        = $clog2(W),
  localparam int RW         = $clog2(MAX_ROUNDS + 1),
  localparam int AW         = $clog2(2 * MAX_ROUNDS + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [RW-1:0]         in_rounds,
  input  logic [block_w(W)-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [block_w(W)-1:0] out_data,
  input  logic                  sk_we,
  input  logic [AW-1:0]         sk_addr,
  input  logic [W-1:0]          sk_data
);

  localparam int              BW      = block_w(W);
  localparam int              DEPTH   = 2 * MAX_ROUNDS + 2;
  localparam logic [AW:0]     DEPTH_V = (AW + 1)'(DEPTH);
  localparam logic [RW-1:0]   MAX_R   = RW'(MAX_ROUNDS);

  state_t         state_reg, state_next;
  mode_t          mode_reg, mode_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [RW-1:0]  i_reg, i_next;
  logic [RW-1:0]  r_reg, r_next;
  logic [BW-1:0]  out_reg, out_next;

  // Subkey table: small, read at two addresses per cycle, never reset.
  logic [W-1:0]   sk_mem [DEPTH];
  logic [AW-1:0]  addr_even, addr_odd;
  logic [W-1:0]   sk_even, sk_odd, sk0, sk1;

  always_ff @(posedge clk) begin
    if (sk_we && (state_reg == IDLE) && ({1'b0, sk_addr} < DEPTH_V)) begin
      sk_mem[sk_addr] <= sk_data;
    end
  end

  assign addr_even = AW'(i_reg) << 1;
  assign addr_odd  = addr_even | AW'(1);
  assign sk_even   = sk_mem[addr_even];
  assign sk_odd    = sk_mem[addr_odd];
  assign sk0       = sk_mem[0];
  assign sk1       = sk_mem[1];

  // Round datapath. The first rotator produces the half-round word that is
  // updated first (A when encrypting, B when decrypting); the second is
  // chained on it and produces the other word.
  logic         dec;
  logic [W-1:0] rot1_in, rot1_out, rot2_in, rot2_out;
  logic [W-1:0] first_word, second_word, rnd_a, rnd_b;

  assign dec     = (mode_reg == DEC);
  assign rot1_in = dec ? (b_reg - sk_odd) : (a_reg ^ b_reg);

  rc5_rot #(.W(W)) u_rot_a (
    .data   (rot1_in),
    .amt    (dec ? a_reg[LGW-1:0] : b_reg[LGW-1:0]),
    .dir    (dec),
    .result (rot1_out)
  );

  assign first_word = dec ? (rot1_out ^ a_reg) : (rot1_out + sk_even);
  assign rot2_in    = dec ? (a_reg - sk_even) : (b_reg ^ first_word);

  rc5_rot #(.W(W)) u_rot_b (
    .data   (rot2_in),
    .amt    (first_word[LGW-1:0]),
    .dir    (dec),
    .result (rot2_out)
  );

  assign second_word = dec ? (rot2_out ^ first_word) : (rot2_out + sk_odd);
  assign rnd_a       = dec ? second_word : first_word;
  assign rnd_b       = dec ? first_word : second_word;

  // Accept-time values.
  logic [RW-1:0] r_acc;
  logic [W-1:0]  in_a, in_b;

  assign r_acc = (in_rounds > MAX_R) ? MAX_R : in_rounds;
  assign in_a  = in_data[W-1:0];
  assign in_b  = in_data[BW-1:W];

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    i_next     = i_reg;
    r_next     = r_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          mode_next = mode_t'(in_mode);
          r_next    = r_acc;
          if (in_mode) begin
            a_next = in_a;
            b_next = in_b;
            i_next = r_acc;
          end else begin
            a_next = in_a + sk0;
            b_next = in_b + sk1;
            i_next = RW'(1);
          end
          if (r_acc != '0) begin
            state_next = RUN;
          end else begin
            // Zero rounds: whitening only; decrypt removes it straight away.
            state_next = DONE;
            out_next   = in_mode ? {b_next - sk1, a_next - sk0} : {b_next, a_next};
          end
        end
      end
      RUN: begin
        a_next = rnd_a;
        b_next = rnd_b;
        if (dec ? (i_reg == RW'(1)) : (i_reg == r_reg)) begin
          state_next = DONE;
          out_next   = dec ? {b_next - sk1, a_next - sk0} : {b_next, a_next};
        end else begin
          i_next = dec ? (i_reg - RW'(1)) : (i_reg + RW'(1));
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      mode_reg  <= ENC;
      a_reg     <= '0;
      b_reg     <= '0;
      i_reg     <= '0;
      r_reg     <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      i_reg     <= i_next;
      r_reg     <= r_next;
      out_reg   <= out_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = out_reg;

endmodule

// File: doc/rc5_core.md
Name: rc5_core

Overview:
- Parametrised RC5-W/R/b block cipher datapath, successor to the fixed 16-bit, 16-round encrypt-only engine.
- Encrypts and decrypts one 2W-bit block per transaction, one round per clock, for a runtime round count up to MAX_ROUNDS.
- Valid/ready handshakes on both input and output.
- Subkey table S[] is written by the key-schedule block (or by software) through a dedicated write port; the core only consumes it.

Parameters:
- W, 16, word width in bits; legal values 16, 32, 64; block width is 2W.
- MAX_ROUNDS, 16, maximum supported rounds; table depth is 2*MAX_ROUNDS+2.
- LGW, $clog2(W), rotate-amount width (derived; do not override).
- RW, $clog2(MAX_ROUNDS+1), round-count width (derived).
- AW, $clog2(2*MAX_ROUNDS+2), subkey address width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input block present.
- in_ready  out  1  core can accept a block.
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- in_rounds  in  RW  rounds r; sampled on accept.
- in_data  in  2W  block; [W-1:0] = A, [2W-1:W] = B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- out_data  out  2W  result; {B,A}.
- sk_we  in  1  subkey write strobe.
- sk_addr  in  AW  subkey index.
- sk_data  in  W  subkey value.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, A=B=0, round counter 0, out_valid=0, out_data=0, in_ready=1.
  - Subkey table is NOT reset.
  - Reset mid-operation abandons the block with no output.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE). Accept happens when in_valid && in_ready on a clock edge.
- Accept at edge t:
  - Latch mode.
  - Latch r = min(in_rounds, MAX_ROUNDS).
  - Encrypt loads A = in_A + S[0], B = in_B + S[1], i = 1.
  - Decrypt loads A = in_A, B = in_B, i = r.
  - Next state is RUN if r > 0, else DONE.
- RUN performs one round per cycle. All arithmetic is mod 2^W; rotate amount uses the low LGW bits.
  - Encrypt: A' = ROTL(A^B, B) + S[2i]; then B' = ROTL(B^A', A') + S[2i+1]; i increments. Leave RUN after the round where i == r.
  - Decrypt: B' = ROTR(B - S[2i+1], A) ^ A; then A' = ROTR(A - S[2i], B') ^ B'; i decrements. Leave RUN after the round where i == 1.
- Entering DONE registers out_data:
  - Encrypt: {B, A}.
  - Decrypt: {B - S[1], A - S[0]}.
- Latency: out_valid is high from cycle t+r+1. For r = 0 this is t+1 (pure whitening or un-whitening).
- DONE holds out_valid=1 and out_data stable until out_ready is high on an edge, then goes to IDLE.
  - No new accept in the same cycle as the result handoff; in_ready rises the cycle after.
  - out_valid must not drop without a handshake.
- Subkey writes:
  - Take effect at the edge only in IDLE.
  - In RUN/DONE, sk_we is dropped silently.
  - sk_addr >= 2*MAX_ROUNDS+2 is ignored.
- in_mode and in_rounds are ignored outside the accept cycle. in_valid held high while busy is harmless.

Decomposition:
- Package rc5_pkg:
  - state enum {IDLE, RUN, DONE}.
  - mode enum {ENC, DEC}.
  - Magic constants P_w/Q_w for W = 16/32/64 (shared with the key-schedule block).
  - Function block_w(W) = 2*W.
- Sub-module rc5_rot #(W):
  - Inputs data, amt[LGW-1:0], dir (0 = left, 1 = right).
  - Output is the rotated word; purely combinational.
  - Two instances: A-path and B-path, with B-path chained on A-path output.

Test Plan:
- W=16: write all S = 0; encrypt r=1, in_data=0x0000_0001 -> out_data=0x0002_0001, out_valid at t+2.
- W=16: S[0]=0x0010, S[1]=0x0020; encrypt r=0, in_data=0x0001_0002 -> out_data=0x0021_0012 at t+1. Decrypt r=0 of 0x0021_0012 -> 0x0001_0002.
- Random S[], W=16 and W=32, r in {1, 7, MAX_ROUNDS}, 200 random blocks: decrypt(encrypt(x)) == x. Each result appears exactly at t+r+1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, extra in_valid ignored; out_ready=1 -> in_ready=1 the next cycle.
- in_rounds=20 with MAX_ROUNDS=16 -> identical result to r=16, out_valid at t+17. A sk_we write to S[2] during RUN does not alter the result, and a re-read via an r=1 encrypt shows the old value.
- Pull rst low during round 3 -> out_valid=0 and in_ready=1 immediately (asynchronous). After release, a fresh encrypt with the same inputs returns the correct result.
